// File: rtl/ad9826_spi_master.sv
`default_nettype none
// ============================================================================
// Module      : ad9826_spi_master
// Description : AD9826 three-wire serial port master. Sends one 16-bit
//               SLOAD/SCLK/SDATA frame per write/read command; reads turn the
//               data line around and return the 9-bit word with a strobe.
//               Read support is built only when AD9826_SPI_RD_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module ad9826_spi_master #(
    parameter int SCLK_HALF = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_in,
    input  logic [8:0] wr_data_in,
    input  logic [2:0] addr_in,
    input  logic       rd_in,
    output logic [8:0] rd_data_o,
    output logic       rd_data_valid_o,
    output logic       ready_o,
    output logic       done_o,
    output logic       sclk_o,
    output logic       sload_o,
    output logic       sdata_o,
    input  logic       sdata_i,
    output logic       tri_en
);

    localparam int                c_PH_W    = $clog2(SCLK_HALF) + 1;
    localparam logic [c_PH_W-1:0] c_PH_LAST = c_PH_W'(SCLK_HALF - 1);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_SETUP = 3'd1;
    localparam logic [2:0] c_SHIFT = 3'd2;
    localparam logic [2:0] c_STOP  = 3'd3;
    localparam logic [2:0] c_DONE  = 3'd4;

    logic [2:0]        r_state, w_state_nx;
    logic [3:0]        r_bit, w_bit_nx;
    logic [c_PH_W-1:0] r_ph, w_ph_nx;
    logic              r_hi, w_hi_nx;
    logic              r_last, w_last_nx;
    logic [15:0]       r_frame, w_frame_nx;

    logic w_rd_go;
    logic w_accept;
    logic w_ph_end;

    logic w_ready_nx, w_sload_nx, w_sclk_nx, w_sdata_nx, w_tri_nx, w_done_nx;
    logic r_ready, r_sload, r_sclk, r_sdata, r_done;

`ifdef AD9826_SPI_RD_EN
    assign w_rd_go = rd_in & ~wr_in;
`else
    assign w_rd_go = 1'b0;
`endif

    assign w_accept   = (r_state == c_IDLE) & (wr_in | w_rd_go);
    assign w_ph_end   = (r_ph == c_PH_LAST);
    // Next frame must be visible on the accept cycle so SETUP already shows bit 15.
    assign w_frame_nx = w_accept ? {w_rd_go, addr_in, 3'b000, w_rd_go ? 9'h000 : wr_data_in}
                                 : r_frame;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
            r_bit   <= 4'd0;
            r_ph    <= '0;
            r_hi    <= 1'b0;
            r_last  <= 1'b0;
            r_frame <= 16'h0000;
        end else begin
            r_state <= w_state_nx;
            r_bit   <= w_bit_nx;
            r_ph    <= w_ph_nx;
            r_hi    <= w_hi_nx;
            r_last  <= w_last_nx;
            r_frame <= w_frame_nx;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nx = r_state;
        w_bit_nx   = r_bit;
        w_ph_nx    = r_ph;
        w_hi_nx    = r_hi;
        w_last_nx  = r_last;
        case (r_state)
            c_IDLE: begin
                if (w_accept) begin
                    w_state_nx = c_SETUP;
                    w_bit_nx   = r_bit - 4'd1;
                    w_ph_nx    = '0;
                    w_hi_nx    = 1'b0;
                    w_last_nx  = 1'b0;
                end
            end
            c_SETUP: begin
                if (w_ph_end) begin
                    w_state_nx = c_SHIFT;
                    w_ph_nx    = '0;
                    w_hi_nx    = 1'b1;
                end else begin
                    w_ph_nx = r_ph + 1'b1;
                end
            end
            c_SHIFT: begin
                if (w_ph_end) begin
                    w_ph_nx = '0;
                    if (r_hi) begin
                        // Falling edge: advance data, or flag the trailing low phase of bit 0.
                        w_hi_nx = 1'b0;
                        if (r_bit == 4'd0) begin
                            w_last_nx = 1'b1;
                        end else begin
                            w_bit_nx = r_bit - 4'd1;
                        end
                    end else if (r_last) begin
                        w_state_nx = c_STOP;
                    end else begin
                        w_hi_nx = 1'b1;
                    end
                end else begin
                    w_ph_nx = r_ph + 1'b1;
                end
            end
            c_STOP: begin
                if (w_ph_end) begin
                    w_state_nx = c_DONE;
                    w_ph_nx    = '0;
                end else begin
                    w_ph_nx = r_ph + 1'b1;
                end
            end
            c_DONE:  w_state_nx = c_IDLE;
            default: w_state_nx = c_IDLE;
        endcase
    end

    // Output decode from next state, registered below
    always_comb begin
        w_ready_nx = (w_state_nx == c_IDLE);
        w_sload_nx = !((w_state_nx == c_SETUP) || (w_state_nx == c_SHIFT));
        w_sclk_nx  = (w_state_nx == c_SHIFT) && w_hi_nx;
        w_tri_nx   = w_frame_nx[15] && (w_state_nx == c_SHIFT) && (w_bit_nx <= 4'd8);
        w_sdata_nx = !w_sload_nx && !w_tri_nx && w_frame_nx[w_bit_nx];
        w_done_nx  = (w_state_nx == c_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ready <= 1'b1;
            r_sload <= 1'b1;
            r_sclk  <= 1'b0;
            r_sdata <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_ready <= w_ready_nx;
            r_sload <= w_sload_nx;
            r_sclk  <= w_sclk_nx;
            r_sdata <= w_sdata_nx;
            r_done  <= w_done_nx;
        end
    end

    assign ready_o = r_ready;
    assign sload_o = r_sload;
    assign sclk_o  = r_sclk;
    assign sdata_o = r_sdata;
    assign done_o  = r_done;

`ifdef AD9826_SPI_RD_EN
    logic [8:0] r_cap;
    logic [8:0] r_rd_data;
    logic       r_valid;
    logic       r_tri;

    // Sample at the end of the high phase of bits 8..0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cap <= 9'h000;
        end else if (r_frame[15] && (r_state == c_SHIFT) && r_hi && w_ph_end
                     && (r_bit <= 4'd8)) begin
            r_cap <= {r_cap[7:0], sdata_i};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tri     <= 1'b0;
            r_valid   <= 1'b0;
            r_rd_data <= 9'h000;
        end else begin
            r_tri   <= w_tri_nx;
            r_valid <= w_done_nx && r_frame[15];
            if (w_done_nx && r_frame[15]) begin
                r_rd_data <= r_cap;
            end
        end
    end

    assign tri_en          = r_tri;
    assign rd_data_valid_o = r_valid;
    assign rd_data_o       = r_rd_data;
`else
    logic w_unused;
    assign w_unused        = ^{rd_in, sdata_i, w_tri_nx};
    assign tri_en          = 1'b0;
    assign rd_data_valid_o = 1'b0;
    assign rd_data_o       = 9'h000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ad9826_spi_master.sv
`default_nettype none
// Self-checking bench for ad9826_spi_master: frame scoreboard fed by an ADC
// model on dut0 (SCLK_HALF=2) plus a direct SCLK_HALF=1 write on dut1.
module tb_ad9826_spi_master;

    localparam int SH = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_in, rd_in;
    logic [8:0] wr_data_in;
    logic [2:0] addr_in;
    logic [8:0] rd_data_o;
    logic       rd_data_valid_o, ready_o, done_o, sclk_o, sload_o, sdata_o, tri_en;
    logic       sdata_in;

    logic       wr1;
    logic [8:0] d1;
    logic [2:0] a1;
    logic [8:0] o1_rd_data;
    logic       o1_valid, o1_ready, o1_done, o1_sclk, o1_sload, o1_sdata, o1_tri;

    int n_checks = 0;
    int n_err    = 0;

    logic [15:0] q_frame[$];
    logic [8:0]  q_rd[$];
    logic [8:0]  adc_word;

    logic [15:0] m_frame, m_tri;
    int          m_bits;
    logic        m_prev_sclk, m_prev_sload;

    always #5 clk = ~clk;

    ad9826_spi_master #(.SCLK_HALF(SH)) dut0 (
        .clk(clk), .rst_n(rst_n), .wr_in(wr_in), .wr_data_in(wr_data_in),
        .addr_in(addr_in), .rd_in(rd_in), .rd_data_o(rd_data_o),
        .rd_data_valid_o(rd_data_valid_o), .ready_o(ready_o), .done_o(done_o),
        .sclk_o(sclk_o), .sload_o(sload_o), .sdata_o(sdata_o),
        .sdata_i(sdata_in), .tri_en(tri_en)
    );

    ad9826_spi_master #(.SCLK_HALF(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .wr_in(wr1), .wr_data_in(d1),
        .addr_in(a1), .rd_in(1'b0), .rd_data_o(o1_rd_data),
        .rd_data_valid_o(o1_valid), .ready_o(o1_ready), .done_o(o1_done),
        .sclk_o(o1_sclk), .sload_o(o1_sload), .sdata_o(o1_sdata),
        .sdata_i(1'b0), .tri_en(o1_tri)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // ADC model and frame monitor on dut0
    always @(negedge clk) begin
        if (!rst_n) begin
            m_frame      = 16'h0;
            m_tri        = 16'h0;
            m_bits       = 0;
            m_prev_sclk  = 1'b0;
            m_prev_sload = 1'b1;
            sdata_in     = 1'b0;
        end else begin
            if (sclk_o && !m_prev_sclk && !sload_o) begin
                int bn;
                m_frame = {m_frame[14:0], sdata_o};
                m_tri   = {m_tri[14:0], tri_en};
                m_bits++;
                bn = 16 - m_bits;
                sdata_in = (bn >= 0 && bn <= 8) ? adc_word[bn] : 1'b0;
            end
            if (sload_o && !m_prev_sload) begin
                if (q_frame.size() == 0) begin
                    check("frame_extra", 1, 0);
                end else begin
                    logic [15:0] e;
                    e = q_frame.pop_front();
                    check("frame", m_frame, e);
                    check("frame_bits", m_bits, 16);
                    check("tri_mask", m_tri, e[15] ? 16'h01FF : 16'h0000);
                end
                m_frame = 16'h0;
                m_tri   = 16'h0;
                m_bits  = 0;
            end
            if (rd_data_valid_o) begin
                if (q_rd.size() == 0) begin
                    check("valid_extra", 1, 0);
                end else begin
                    check("rd_data", rd_data_o, q_rd.pop_front());
                    check("valid_with_done", done_o, 1);
                end
            end
            m_prev_sclk  = sclk_o;
            m_prev_sload = sload_o;
        end
    end

    task automatic issue(input logic w, input logic r, input logic [2:0] a,
                         input logic [8:0] d, input logic [8:0] adc, input bit hold);
        logic is_rd;
        int   n;
        bit   busy_bad;
        @(negedge clk);
        check("ready_before", ready_o, 1);
        is_rd = r & ~w;
        q_frame.push_back({is_rd, a, 3'b000, is_rd ? 9'h000 : d});
        if (is_rd) q_rd.push_back(adc);
        adc_word   = adc;
        wr_in      = w;
        rd_in      = r;
        addr_in    = a;
        wr_data_in = d;
        @(posedge clk);
        n = 1;
        #1;
        if (!hold) begin
            wr_in = 1'b0;
            rd_in = 1'b0;
        end
        busy_bad = 1'b0;
        while (1) begin
            @(negedge clk);
            if (n == 1)      check("sload_fall", sload_o, 0);
            if (n == SH)     check("setup_sclk_low", sclk_o, 0);
            if (n == 1 + SH) check("first_rise", sclk_o, 1);
            if (done_o || n > 200) break;
            if (ready_o) busy_bad = 1'b1;
            @(posedge clk);
            n++;
        end
        check("done_cycle", n, 1 + 34 * SH);
        check("busy_ready", busy_bad, 0);
        check("ready_in_done", ready_o, 0);
        check("valid_at_done", rd_data_valid_o, is_rd);
        wr_in = 1'b0;
        rd_in = 1'b0;
        @(negedge clk);
        check("ready_after", ready_o, 1);
        check("sload_after", sload_o, 1);
    endtask

    initial begin
        int  n, rises, notog, bad;
        logic prev;
        logic [15:0] fr;

        rst_n = 1'b0; wr_in = 1'b0; rd_in = 1'b0; wr_data_in = 9'h0; addr_in = 3'h0;
        wr1 = 1'b0; d1 = 9'h0; a1 = 3'h0; adc_word = 9'h0; sdata_in = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", ready_o, 1);
        check("rst_done", done_o, 0);
        check("rst_valid", rd_data_valid_o, 0);
        check("rst_rd_data", rd_data_o, 0);
        check("rst_sclk", sclk_o, 0);
        check("rst_sload", sload_o, 1);
        check("rst_sdata", sdata_o, 0);
        check("rst_tri", tri_en, 0);
        rst_n = 1'b1;

        issue(1'b1, 1'b0, 3'd0, 9'h0C8, 9'h000, 1'b0);
`ifdef AD9826_SPI_RD_EN
        issue(1'b0, 1'b1, 3'd1, 9'h000, 9'h0C0, 1'b0);
        issue(1'b0, 1'b1, 3'd7, 9'h0AA, 9'h155, 1'b0);
`endif
        issue(1'b1, 1'b1, 3'd5, 9'h1FF, 9'h000, 1'b1);
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (!sload_o || !ready_o) bad++;
        end
        check("idle_after_held", bad, 0);

        // SCLK_HALF=1 write on dut1
        @(negedge clk);
        wr1 = 1'b1; a1 = 3'd2; d1 = 9'h000;
        @(posedge clk);
        n = 1;
        #1 wr1 = 1'b0;
        prev = o1_sclk; rises = 0; notog = 0; fr = 16'h0;
        while (1) begin
            @(negedge clk);
            if (o1_sclk && !prev) begin
                rises++;
                fr = {fr[14:0], o1_sdata};
            end
            if (n >= 2 && n <= 33 && o1_sclk == prev) notog++;
            if (o1_done || n > 100) break;
            prev = o1_sclk;
            @(posedge clk);
            n++;
        end
        check("h1_done_cycle", n, 35);
        check("h1_rises", rises, 16);
        check("h1_toggle", notog, 0);
        check("h1_frame", fr, 16'h2000);

`ifdef AD9826_SPI_RD_EN
        // Abort a read during bit 6
        @(negedge clk);
        adc_word = 9'h1A5;
        rd_in = 1'b1; addr_in = 3'd3;
        @(posedge clk);
        #1 rd_in = 1'b0;
        n = 0;
        while (m_bits < 10 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("abort_reached_bit6", m_bits >= 10, 1);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort_sload", sload_o, 1);
        check("abort_tri", tri_en, 0);
        check("abort_ready", ready_o, 1);
        check("abort_sclk", sclk_o, 0);
        rst_n = 1'b1;
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (done_o || rd_data_valid_o) bad++;
        end
        check("abort_no_done", bad, 0);
`else
        // Reads are not accepted in this build
        @(negedge clk);
        rd_in = 1'b1; addr_in = 3'd1;
        bad = 0;
        repeat (80) begin
            @(negedge clk);
            if (!ready_o || !sload_o || tri_en || sclk_o) bad++;
        end
        rd_in = 1'b0;
        check("rd_ignored", bad, 0);
`endif

        repeat (5) @(negedge clk);
        check("frames_pending", q_frame.size(), 0);
        check("reads_pending", q_rd.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ad9826_spi_master.md
# ad9826_spi_master

Three-wire serial port master for the AD9826 ADC. It sits directly downstream of the AD9826 configuration sequencer, which issues single-register write and read commands. It turns each command into one 16-bit SLOAD/SCLK/SDATA frame, turns the data line around for reads, and returns the read word with a valid strobe. One command is in flight at a time; `ready_o`/`done_o` pace the sequencer.

## Interface
- `SCLK_HALF`, default 2: SCLK half-period in `clk` cycles; legal values ≥1.
- `clk` in 1: system clock; all logic on rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `wr_in` in 1: write command; accepted only when `ready_o`=1.
- `wr_data_in` in 9: register data for writes.
- `addr_in` in 3: register address, for reads and writes.
- `rd_in` in 1: read command; accepted only when `ready_o`=1.
- `rd_data_o` out 9: last read word; holds until the next read completes.
- `rd_data_valid_o` out 1: one-cycle strobe with `rd_data_o` at the end of a read.
- `ready_o` out 1: idle, command may be issued this cycle.
- `done_o` out 1: one-cycle strobe at the end of every frame (read or write).
- `sclk_o` out 1: serial clock to the ADC; idles low.
- `sload_o` out 1: frame select, active-low; idles high.
- `sdata_o` out 1: serial data driven to the pad.
- `sdata_i` in 1: serial data from the pad.
- `tri_en` out 1: 1 means the pad output buffer is disabled and the ADC drives SDATA.

## Operation
- Frame is 16 bits, MSB first: bit15 R/W (1=read), bits14..12 A2..A0, bits11..9 zero, bits8..0 D8..D0. Read frames send zeros in D8..D0.
- Accept happens on a cycle with `ready_o`=1 and `wr_in|rd_in`. If both are high, the write wins. Address, data and type are latched. Commands while not idle are ignored.
- States:
  - IDLE: `ready_o`=1.
  - SETUP: `sload_o`=0, `sclk_o`=0, `sdata_o`=bit15, for `SCLK_HALF` cycles.
  - SHIFT: for each bit 15..0, `sclk_o`=1 for `SCLK_HALF` cycles, then 0 for `SCLK_HALF` cycles. `sdata_o` changes to the next bit only when the high phase ends (falling edge). The ADC samples on the rising edge.
  - STOP: `sload_o`=1, `sclk_o`=0, `tri_en`=0, for `SCLK_HALF` cycles.
  - DONE: one cycle, then back to IDLE.
- Read turnaround: `tri_en` rises when the high phase of bit 9 ends and stays 1 through the last SHIFT cycle. While `tri_en`=1, `sdata_o`=0.
- Read capture: `sdata_i` is sampled on the last `clk` cycle of the high phase of bits 8..0 and shifted MSB-first into a 9-bit register.
- DONE cycle: `done_o`=1. For reads, also `rd_data_valid_o`=1 and `rd_data_o` is updated with the captured word in that same cycle.
- Bit and phase counters:
  - 4-bit bit index, wraps 0→15 only at frame start.
  - Phase counter width is $clog2(SCLK_HALF)+1.
  - No arithmetic overflow is possible inside a frame.

## Timing
- Reset values: `ready_o`=1, `done_o`=0, `rd_data_valid_o`=0, `rd_data_o`=0, `sclk_o`=0, `sload_o`=1, `sdata_o`=0, `tri_en`=0. State is IDLE.
- All outputs are registered.
- Accept at cycle T:
  - `ready_o`=0 from T+1 through the DONE cycle, inclusive.
  - `sload_o` falls at T+1.
  - The first `sclk_o` rise is at T+1+`SCLK_HALF`.
  - `done_o` is at T+1+34·`SCLK_HALF` (T+69 for default).
  - `ready_o`=1 the cycle after DONE.
- Back-to-back frames: the minimum spacing between `sload_o` falls is 34·`SCLK_HALF`+2 cycles.
- A sequencer that holds `wr_in=ready_o` combinationally must see exactly one accept per frame. `ready_o`=0 during DONE guarantees this.
- Reset mid-frame: the frame is aborted and all outputs take their reset values on the next cycle. There is no `done_o` for the aborted frame.

## Configuration
- `AD9826_SPI_RD_EN` defined: read support is as described above.
- `AD9826_SPI_RD_EN` undefined:
  - `rd_in` is ignored and is never accepted, even when `wr_in`=0.
  - `tri_en` is tied 0.
  - `rd_data_valid_o` is tied 0 and `rd_data_o` is tied 0.
  - The capture register is removed.
  - Write frames are unchanged.

## Test plan
- Write, default `SCLK_HALF`: `wr_in`=1, `addr_in`=0, `wr_data_in`=0x0C8 → 16 rising-edge samples read 0x00C8 MSB-first, `tri_en` stays 0, `done_o` at T+69, `rd_data_valid_o` stays 0.
- Read: `rd_in`=1, `addr_in`=1, ADC model returns 0x0C0 → bits 15..12 = 1,0,0,1; `tri_en` 1 from the bit-9 falling edge to frame end; `rd_data_o`=0x0C0 with `rd_data_valid_o`=`done_o`=1 at T+69.
- Simultaneous `wr_in`=`rd_in`=1 with `addr_in`=5, `wr_data_in`=0x1FF → write frame 0x51FF, no valid strobe. Also: commands held high while busy → no second frame until after DONE.
- `SCLK_HALF`=1: write of 0x000 to addr 2 → `sclk_o` toggles every cycle, `done_o` at T+35.
- `rst_n`=0 during bit 6 of a read → next cycle `sload_o`=1, `tri_en`=0, `ready_o`=1, and no `done_o` or `rd_data_valid_o` ever appears for that frame.
- Build with `AD9826_SPI_RD_EN` undefined: `rd_in`=1 → `ready_o` stays 1, no `sload_o` activity, `tri_en`=0.
